frame_streamer: RTL and testbench



---
 rtl/frame_streamer.sv | 201 ++++++++++++++++++++
 tb/tb_frame_streamer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// Streams one frame from a 1-cycle-latency frame buffer onto a valid/ready port.
// A 2-entry FIFO plus a bypass of the returning read keeps first-beat latency at 2 cycles.
module frame_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   frame_len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   rd_cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  inflight_r;
    logic                  inflight_last_r;
    logic [1:0]            fifo_cnt_r;
    logic [DATA_WIDTH-1:0] data0_r;
    logic [DATA_WIDTH-1:0] data1_r;
    logic                  last0_r;
    logic                  last1_r;

    logic                  head_valid_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  head_last_s;
    logic                  pop_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic [2:0]            occ_next_s;
    logic                  issue_s;
    logic                  issue_last_s;

    // Head of the stream: oldest FIFO entry, else the read returning this cycle.
    always_comb begin
        head_valid_s = 1'b0;
        head_data_s  = {DATA_WIDTH{1'b0}};
        head_last_s  = 1'b0;
        if (fifo_cnt_r != 2'd0) begin
            head_valid_s = 1'b1;
            head_data_s  = data0_r;
            head_last_s  = last0_r;
        end else if (inflight_r) begin
            head_valid_s = 1'b1;
            head_data_s  = mem_rdata;
            head_last_s  = inflight_last_r;
        end else begin
            head_valid_s = 1'b0;
        end
    end

    assign pop_s       = head_valid_s & m_ready;
    assign fifo_pop_s  = pop_s & (fifo_cnt_r != 2'd0);
    assign fifo_push_s = inflight_r & ~((fifo_cnt_r == 2'd0) & pop_s);
    // Words held after this edge; a new read may only issue if one slot stays free.
    assign occ_next_s  = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};

    // Read issue decision for the current cycle.
    always_comb begin
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        if ((state_r == FETCH) && (rd_cnt_r < len_r) && (occ_next_s < 3'd2)) begin
            issue_s      = 1'b1;
            issue_last_s = (rd_cnt_r == (len_r - {{ADDR_WIDTH{1'b0}}, 1'b1}));
        end else begin
            issue_s      = 1'b0;
            issue_last_s = 1'b0;
        end
    end

    // Frame sequencing FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            len_r    <= {(ADDR_WIDTH+1){1'b0}};
            rd_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        len_r    <= frame_len;
                        rd_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
                        busy_r   <= 1'b1;
                        if (frame_len == {(ADDR_WIDTH+1){1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue_s) begin
                        rd_cnt_r <= rd_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                        if (issue_last_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (occ_next_s == 3'd0) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return tracking and the 2-entry output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            fifo_cnt_r      <= 2'd0;
            data0_r         <= {DATA_WIDTH{1'b0}};
            data1_r         <= {DATA_WIDTH{1'b0}};
            last0_r         <= 1'b0;
            last1_r         <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_last_s;
            case (fifo_cnt_r)
                2'd0: begin
                    if (fifo_push_s) begin
                        data0_r    <= mem_rdata;
                        last0_r    <= inflight_last_r;
                        fifo_cnt_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (fifo_pop_s && fifo_push_s) begin
                        data0_r <= mem_rdata;
                        last0_r <= inflight_last_r;
                    end else if (fifo_pop_s) begin
                        fifo_cnt_r <= 2'd0;
                    end else if (fifo_push_s) begin
                        data1_r    <= mem_rdata;
                        last1_r    <= inflight_last_r;
                        fifo_cnt_r <= 2'd2;
                    end
                end
                2'd2: begin
                    if (fifo_pop_s) begin
                        data0_r <= data1_r;
                        last0_r <= last1_r;
                        if (fifo_push_s) begin
                            data1_r <= mem_rdata;
                            last1_r <= inflight_last_r;
                        end else begin
                            fifo_cnt_r <= 2'd1;
                        end
                    end
                end
                default: begin
                    fifo_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_en   = issue_s;
    assign mem_addr = rd_cnt_r[ADDR_WIDTH-1:0];
    assign m_valid  = head_valid_s;
    assign m_data   = head_data_s;
    assign m_last   = head_last_s;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: stimulus queues expected beats, a negedge
// monitor pops and compares them on every handshake.
module tb_frame_streamer;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   frame_len;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    frame_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;
    beat_t exp_q[$];
    beat_t e;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int base = 0;
    int issued = 0, popped = 0, max_ahead = 0;
    int frame_issued = 0, last_addr = 0, last_hs_cyc = 0;
    int done_seen = 0, done_cyc = 0, valid_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: scoreboard pops, read-address order, stall stability, done tracking.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 1'b0;
            issued       = 0;
            popped       = 0;
            frame_issued = 0;
        end else begin
            if (m_valid) valid_cnt++;
            if (mem_en) begin
                check("rd_addr", longint'(mem_addr), longint'(frame_issued));
                last_addr = int'(mem_addr);
                frame_issued++;
                issued++;
            end
            if (prev_stall) begin
                check("hold_valid", longint'(m_valid), 64'd1);
                check("hold_data", longint'(m_data), longint'(prev_data));
                check("hold_last", longint'(m_last), longint'(prev_last));
            end
            if (m_valid && m_ready) begin
                popped++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", longint'(m_data), longint'(e.data));
                    check("beat_last", longint'(m_last), longint'(e.last));
                    if (e.cyc >= 0) check("beat_cycle", longint'(cyc - base), longint'(e.cyc));
                end
            end
            if (issued - popped > max_ahead) max_ahead = issued - popped;
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                frame_issued = 0;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        return (mode == 0) ? 1'b1 : (pat[k % 6] != 0);
    endfunction

    // mode 0: m_ready held high; mode 1: 1,0,0,1,0,1 pattern. Optional second start at cycle 3.
    task automatic run_frame(input int len, input int mode, input int extra_len);
        int d0, k, v0, i0, exp_done;
        d0 = done_seen;
        v0 = valid_cnt;
        i0 = issued;
        for (int i = 0; i < len; i++)
            exp_q.push_back('{data: mem[i], last: (i == len - 1), cyc: (mode == 0) ? 2 + i : -1});
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = (AW+1)'(len);
        base = cyc;
        m_ready = ready_for(mode, 0);
        k = 0;
        while (done_seen == d0 && k < 3000) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            m_ready = ready_for(mode, k);
            if (extra_len > 0 && k == 3) begin
                start = 1'b1;
                frame_len = (AW+1)'(extra_len);
            end
            if (k == 1) begin
                check("busy_c1", longint'(busy), 64'd1);
                if (len > 0) begin
                    check("mem_en_c1", longint'(mem_en), 64'd1);
                    check("mem_addr_c1", longint'(mem_addr), 64'd0);
                end
            end
        end
        if (done_seen == d0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", k);
        end else begin
            exp_done = (mode == 0) ? ((len == 0) ? 1 : len + 2) : (last_hs_cyc - base + 1);
            check("done_cycle", longint'(done_cyc - base), longint'(exp_done));
            if (len == 0) begin
                check("len0_no_valid", longint'(valid_cnt - v0), 64'd0);
                check("len0_no_read", longint'(issued - i0), 64'd0);
            end else begin
                check("last_addr", longint'(last_addr), longint'(len - 1));
            end
            @(negedge clk);
            check("busy_low", longint'(busy), 64'd0);
        end
        check("queue_empty", longint'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 256);
        rst = 1'b1; start = 1'b0; frame_len = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", longint'(busy), 64'd0);
        check("rst_done", longint'(done), 64'd0);
        check("rst_mem_en", longint'(mem_en), 64'd0);
        check("rst_valid", longint'(m_valid), 64'd0);

        run_frame(4, 0, 0);
        run_frame(8, 1, 0);
        run_frame(1, 0, 0);
        run_frame(0, 0, 0);
        run_frame(1024, 0, 0);
        run_frame(8, 0, 5);

        // Reset after three beats of a stalled len=16 frame.
        for (int i = 0; i < 3; i++) exp_q.push_back('{data: mem[i], last: 1'b0, cyc: 2 + i});
        @(posedge clk); #1;
        start = 1'b1; frame_len = (AW+1)'(16); base = cyc; m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            m_ready = (k <= 4);
            if (k == 8) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = done_seen;
        @(negedge clk);
        check("mrst_busy", longint'(busy), 64'd0);
        check("mrst_done", longint'(done), 64'd0);
        check("mrst_mem_en", longint'(mem_en), 64'd0);
        check("mrst_mem_addr", longint'(mem_addr), 64'd0);
        check("mrst_valid", longint'(m_valid), 64'd0);
        check("mrst_data", longint'(m_data), 64'd0);
        check("mrst_last", longint'(m_last), 64'd0);
        check("mrst_beats_left", longint'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        check("mrst_no_done", longint'(done_seen - d0), 64'd0);

        run_frame(2, 0, 0);
        check("max_reads_ahead_ok", longint'(max_ahead <= 2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
